// File: rtl/ram_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_unit
// Purpose  : LOAD/STORE/PUSH/POP sequencer in front of a single-port RAM.
// Revision : 1.0
// ============================================================================
module ram_access_unit #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int SP_INIT = (1 << ADDR_W) - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] sp,
    output logic              sp_empty,
    output logic              sp_full,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_wait = 3'd1;
    localparam logic [2:0] c_st_rd_cap  = 3'd2;
    localparam logic [2:0] c_st_wr      = 3'd3;
    localparam logic [2:0] c_st_rsp     = 3'd4;

    localparam logic [1:0] c_op_load  = 2'b00;
    localparam logic [1:0] c_op_store = 2'b01;
    localparam logic [1:0] c_op_push  = 2'b10;
    localparam logic [1:0] c_op_pop   = 2'b11;

    localparam logic [ADDR_W-1:0] c_sp_init    = SP_INIT[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] c_sp_one     = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_count_one  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   c_count_zero = '0;
    localparam logic [ADDR_W:0]   c_count_full = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic              r_req_ready,   w_req_ready_nxt;
    logic              r_rsp_valid,   w_rsp_valid_nxt;
    logic              r_rsp_err,     w_rsp_err_nxt;
    logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic [ADDR_W-1:0] r_sp,          w_sp_nxt;
    logic [ADDR_W:0]   r_count,       w_count_nxt;
    logic              r_sp_empty,    w_sp_empty_nxt;
    logic              r_sp_full,     w_sp_full_nxt;
    logic [ADDR_W-1:0] r_ram_addr,    w_ram_addr_nxt;
    logic [DATA_W-1:0] r_ram_data_in, w_ram_data_in_nxt;
    logic              r_ram_we,      w_ram_we_nxt;

    logic w_accept;
    logic w_req_err;

    assign w_accept  = req_valid && r_req_ready && (r_state == c_st_idle);
    // Stack faults are decided from the registered flags, so no RAM cycle is spent on them.
    assign w_req_err = ((req_op == c_op_push) && r_sp_full) ||
                       ((req_op == c_op_pop)  && r_sp_empty);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_state_nxt = c_st_rsp;
                    end else begin
                        case (req_op)
                            c_op_load:  w_state_nxt = c_st_rd_wait;
                            c_op_store: w_state_nxt = c_st_wr;
                            c_op_push:  w_state_nxt = c_st_wr;
                            default:    w_state_nxt = c_st_rd_wait;
                        endcase
                    end
                end
            end
            c_st_rd_wait: w_state_nxt = c_st_rd_cap;
            c_st_rd_cap:  w_state_nxt = c_st_rsp;
            c_st_wr:      w_state_nxt = c_st_rsp;
            c_st_rsp:     w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        w_ram_addr_nxt    = r_ram_addr;
        w_ram_data_in_nxt = r_ram_data_in;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_sp_nxt          = r_sp;
        w_count_nxt       = r_count;
        w_rsp_err_nxt     = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_rsp_err_nxt = 1'b1;
                    end else begin
                        case (req_op)
                            c_op_load: begin
                                w_ram_addr_nxt = req_addr;
                            end
                            c_op_store: begin
                                w_ram_addr_nxt    = req_addr;
                                w_ram_data_in_nxt = req_wdata;
                            end
                            c_op_push: begin
                                w_ram_addr_nxt    = r_sp;
                                w_ram_data_in_nxt = req_wdata;
                                w_sp_nxt          = r_sp - c_sp_one;
                                w_count_nxt       = r_count + c_count_one;
                            end
                            default: begin
                                w_ram_addr_nxt = r_sp + c_sp_one;
                                w_sp_nxt       = r_sp + c_sp_one;
                                w_count_nxt    = r_count - c_count_one;
                            end
                        endcase
                    end
                end
            end
            c_st_rd_cap: begin
                w_rsp_rdata_nxt = ram_data_out;
            end
            default: begin
            end
        endcase

        w_ram_we_nxt    = (w_state_nxt == c_st_wr);
        w_rsp_valid_nxt = (w_state_nxt == c_st_rsp);
        w_req_ready_nxt = (w_state_nxt == c_st_idle);
        w_sp_empty_nxt  = (w_count_nxt == c_count_zero);
        w_sp_full_nxt   = (w_count_nxt == c_count_full);
    end

    // Registered outputs; reset also kills an in-flight write strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_sp          <= c_sp_init;
            r_count       <= c_count_zero;
            r_sp_empty    <= 1'b1;
            r_sp_full     <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data_in <= '0;
            r_ram_we      <= 1'b0;
        end else begin
            r_req_ready   <= w_req_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_sp          <= w_sp_nxt;
            r_count       <= w_count_nxt;
            r_sp_empty    <= w_sp_empty_nxt;
            r_sp_full     <= w_sp_full_nxt;
            r_ram_addr    <= w_ram_addr_nxt;
            r_ram_data_in <= w_ram_data_in_nxt;
            r_ram_we      <= w_ram_we_nxt;
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;
    assign sp          = r_sp;
    assign sp_empty    = r_sp_empty;
    assign sp_full     = r_sp_full;
    assign ram_addr    = r_ram_addr;
    assign ram_data_in = r_ram_data_in;
    assign ram_we      = r_ram_we;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_unit
// Purpose  : Directed self-checking bench for ram_access_unit with a 32x8 RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_access_unit;

    localparam logic [1:0] c_op_load  = 2'b00;
    localparam logic [1:0] c_op_store = 2'b01;
    localparam logic [1:0] c_op_push  = 2'b10;
    localparam logic [1:0] c_op_pop   = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [4:0] sp;
    logic       sp_empty;
    logic       sp_full;
    logic [4:0] ram_addr;
    logic [7:0] ram_data_in;
    logic       ram_we;
    logic [7:0] ram_data_out;

    logic [7:0] mem [32];
    int         we_cnt = 0;
    logic [4:0] last_waddr;
    logic [7:0] last_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_access_unit #(.ADDR_W(5), .DATA_W(8), .SP_INIT(31)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .sp           (sp),
        .sp_empty     (sp_empty),
        .sp_full      (sp_full),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_we       (ram_we),
        .ram_data_out (ram_data_out)
    );

    // 32x8 RAM: synchronous write, combinational read
    assign ram_data_out = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_data_in;
            we_cnt        <= we_cnt + 1;
            last_waddr    <= ram_addr;
            last_wdata    <= ram_data_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request; lat = edges after the accept edge at which rsp_valid is seen.
    task automatic do_req(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output logic er, output int lat);
        @(negedge clk);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
        #1;
        check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        int         lat;
        int         w0;
        int         pulses;
        int         idx;
        int         acc [4];
        logic [7:0] pop_exp [3];

        req_valid = 1'b0;
        req_op    = c_op_load;
        req_addr  = '0;
        req_wdata = '0;
        pop_exp[0] = 8'h33;
        pop_exp[1] = 8'h22;
        pop_exp[2] = 8'h11;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",    {31'd0, req_ready}, 32'd1);
        check("rst_sp",       {27'd0, sp},        32'd31);
        check("rst_empty",    {31'd0, sp_empty},  32'd1);
        check("rst_full",     {31'd0, sp_full},   32'd0);
        check("rst_we",       {31'd0, ram_we},    32'd0);
        check("rst_rspv",     {31'd0, rsp_valid}, 32'd0);
        check("rst_ram_addr", {27'd0, ram_addr},  32'd0);
        check("rst_rdata",    {24'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // STORE then LOAD
        w0 = we_cnt;
        do_req(c_op_store, 5'd1, 8'hAA, rd, er, lat);
        check("store_lat",   lat,                 32'd1);
        check("store_err",   {31'd0, er},         32'd0);
        check("store_rdata", {24'd0, rd},         32'd0);
        check("store_wecnt", we_cnt - w0,         32'd1);
        check("store_waddr", {27'd0, last_waddr}, 32'd1);
        check("store_wdata", {24'd0, last_wdata}, 32'hAA);
        w0 = we_cnt;
        do_req(c_op_load, 5'd1, 8'h00, rd, er, lat);
        check("load_lat",   lat,         32'd2);
        check("load_rdata", {24'd0, rd}, 32'hAA);
        check("load_err",   {31'd0, er}, 32'd0);
        check("load_wecnt", we_cnt - w0, 32'd0);

        // PUSH x3, POP x3
        do_req(c_op_push, 5'd0, 8'h11, rd, er, lat);
        do_req(c_op_push, 5'd0, 8'h22, rd, er, lat);
        do_req(c_op_push, 5'd0, 8'h33, rd, er, lat);
        check("push_m31", {24'd0, mem[31]},  32'h11);
        check("push_m30", {24'd0, mem[30]},  32'h22);
        check("push_m29", {24'd0, mem[29]},  32'h33);
        check("push_sp",  {27'd0, sp},       32'd28);
        check("push_emp", {31'd0, sp_empty}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            do_req(c_op_pop, 5'd0, 8'h00, rd, er, lat);
            check("pop_rdata", {24'd0, rd}, {24'd0, pop_exp[i]});
            check("pop_err",   {31'd0, er}, 32'd0);
            check("pop_lat",   lat,         32'd2);
        end
        check("pop_sp",  {27'd0, sp},       32'd31);
        check("pop_emp", {31'd0, sp_empty}, 32'd1);

        // POP on empty stack
        w0 = we_cnt;
        do_req(c_op_pop, 5'd0, 8'h00, rd, er, lat);
        check("upop_err",   {31'd0, er},  32'd1);
        check("upop_lat",   lat,          32'd0);
        check("upop_wecnt", we_cnt - w0,  32'd0);
        check("upop_sp",    {27'd0, sp},  32'd31);

        // Four back-to-back STOREs with req_valid held high
        w0 = we_cnt;
        idx = 0;
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            pulses += int'(rsp_valid);
            if (idx < 4) begin
                req_valid = 1'b1;
                req_op    = c_op_store;
                req_addr  = 5'(4 + idx);
                req_wdata = 8'(8'hC0 + idx);
                if (req_ready) begin
                    acc[idx] = c;
                    idx++;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("b2b_accepts", idx,         32'd4);
        check("b2b_gap01",   acc[1] - acc[0], 32'd3);
        check("b2b_gap12",   acc[2] - acc[1], 32'd3);
        check("b2b_gap23",   acc[3] - acc[2], 32'd3);
        check("b2b_pulses",  pulses,      32'd4);
        check("b2b_wecnt",   we_cnt - w0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("b2b_mem", {24'd0, mem[4 + i]}, 32'hC0 + i);
        end

        // Reset asserted while a PUSH is in WR
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = c_op_push;
        req_wdata = 8'h99;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rstwr_we_hi", {31'd0, ram_we}, 32'd1);
        check("rstwr_sp_dec", {27'd0, sp},    32'd30);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstwr_we_lo", {31'd0, ram_we},   32'd0);
        check("rstwr_sp",    {27'd0, sp},       32'd31);
        check("rstwr_emp",   {31'd0, sp_empty}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            pulses += int'(rsp_valid);
        end
        check("rstwr_norsp", pulses,            32'd0);
        check("rstwr_ready", {31'd0, req_ready}, 32'd1);
        check("rstwr_sp2",   {27'd0, sp},        32'd31);
        check("rstwr_mem31", {24'd0, mem[31]},   32'h11);

        // Fill the stack, then overflow
        for (int i = 0; i < 32; i++) begin
            do_req(c_op_push, 5'd0, 8'(8'h40 + i), rd, er, lat);
        end
        check("full_flag", {31'd0, sp_full},  32'd1);
        check("full_sp",   {27'd0, sp},       32'd31);
        check("full_m0",   {24'd0, mem[0]},   32'h5F);
        check("full_m31",  {24'd0, mem[31]},  32'h40);
        w0 = we_cnt;
        do_req(c_op_push, 5'd0, 8'hEE, rd, er, lat);
        check("ovf_err",   {31'd0, er},       32'd1);
        check("ovf_lat",   lat,               32'd0);
        check("ovf_wecnt", we_cnt - w0,       32'd0);
        check("ovf_m31",   {24'd0, mem[31]},  32'h40);
        check("ovf_sp",    {27'd0, sp},       32'd31);
        check("ovf_full",  {31'd0, sp_full},  32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
